mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares the single unified memory port of the multicycle RISC-V core between two requesters: the CPU datapath (fetch, load and store accesses issued by the control FSM) and a DMA/debug loader. It grants one requester at a time and holds the memory command stable for a fixed access latency. It returns a one-cycle completion pulse with captured read data, and alternates fairly when both requesters contend. It sits between the core's IorD/MemRead/MemWrite address mux and the memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles the memory command must be held (legal range ≥1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (low = reset)
- cpu_req  in  1  CPU request level; held until cpu_done
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_gnt  out  1  CPU owns memory (ACCESS/RESP with owner=CPU)
- cpu_done  out  1  one-cycle completion pulse to CPU
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same as cpu_* for DMA
- dma_gnt, dma_done  out  1/1  same as cpu_* for DMA
- rdata  out  DATA_W  captured read data, valid while *_done=1 for reads
- mem_valid  out  1  memory command active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on last ACCESS cycle
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- Registers: state, owner (CPU/DMA), last_owner, cnt (width clog2(MEM_LATENCY+1)), latched we/addr/wdata, rdata.
- IDLE: if no request, stay. Otherwise select winner: single requester wins. With both requesting, winner = requester ≠ last_owner. Latch winner's we/addr/wdata, set owner, cnt←MEM_LATENCY−1, go to ACCESS.
- ACCESS: mem_valid=1, mem_we/addr/wdata driven from latched copies (not live inputs). If cnt≠0: cnt←cnt−1. If cnt=0: for reads rdata←mem_rdata (writes leave rdata unchanged), last_owner←owner, go to RESP.
- RESP: owner's *_done=1 for exactly this cycle, mem_valid=0, go to IDLE.
- *_gnt = (state∈{ACCESS,RESP}) and owner matches; never both high.
- Requester must deassert req in the cycle after its done. A req still high in IDLE is a new request.
- Request inputs change during ACCESS are ignored (latched copies used).
- mem_valid/mem_we/mem_addr/mem_wdata are 0 outside ACCESS.

## Timing
- Reset (async assert): state=IDLE, cnt=0, owner=CPU, last_owner=DMA (CPU wins first tie), rdata=0, all outputs 0. Reset mid-ACCESS aborts the transaction; no done is issued.
- Reset release: first arbitration on the first rising edge with reset high.
- Latency: req high in IDLE cycle T → ACCESS T+1..T+MEM_LATENCY → RESP (done) T+MEM_LATENCY+1 → IDLE T+MEM_LATENCY+2.
- Back-to-back: next grant decided in IDLE cycle after RESP; minimum transaction period MEM_LATENCY+2 cycles.
- Memory samples write on the rising edge ending the last ACCESS cycle.
- Simultaneous requests on first IDLE after reset → CPU. Both continuously requesting → strict alternation.
- MEM_LATENCY=1: single ACCESS cycle, cnt starts at 0.

## Test plan
- Reset then single CPU read addr 0x10 with memory holding 0xDEADBEEF, MEM_LATENCY=2 → mem_valid high cycles 1–2 with mem_addr=0x10, mem_we=0; cpu_done pulse cycle 3 with rdata=0xDEADBEEF; dma_* outputs stay 0.
- DMA write 0x20←0x12345678, then CPU read 0x20 → DMA done first, CPU rdata=0x12345678; rdata unchanged across the write's done.
- Both req high continuously for 4 transactions → grant order CPU, DMA, CPU, DMA; gnt never simultaneous; one IDLE cycle between each.
- CPU changes cpu_addr 0x10→0x40 during ACCESS → mem_addr stays 0x10 through ACCESS.
- Async reset low in middle of ACCESS cycle → outputs 0 immediately (before next edge); no done pulse; after release a fresh CPU request completes normally.
- MEM_LATENCY=1 build: CPU read completes with done at T+2; period 3 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU datapath and a DMA/debug loader.
// One requester owns the port at a time. Its command is latched and held for
// MEM_LATENCY cycles, then a single-cycle done pulse returns the read data.
// When both requesters contend, the grant alternates between them.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic            OWN_CPU  = 1'b0;
  localparam logic            OWN_DMA  = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  cmd_t              cpu_cmd, dma_cmd;

  assign cpu_cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_cmd = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};

  // State register; reset aborts any transaction in flight, CPU wins first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      last_q  <= OWN_DMA;
      cnt_q   <= '0;
      cmd_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
    end
  end

  // Arbitration in IDLE, latency countdown in ACCESS, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req) begin
          // Contention goes to whoever did not finish last.
          if (cpu_req && dma_req) owner_d = ~last_q;
          else                    owner_d = dma_req ? OWN_DMA : OWN_CPU;
          cmd_d   = (owner_d == OWN_DMA) ? dma_cmd : cpu_cmd;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Memory read data is valid on the last ACCESS cycle only.
          if (!cmd_q.we) rdata_d = mem_rdata;
          last_d  = owner_q;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_access, active, in_resp;
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign active    = (state_q != IDLE);

  // Memory command comes only from the latched copy and is zero outside ACCESS.
  assign mem_valid = in_access;
  assign mem_we    = in_access & cmd_q.we;
  assign mem_addr  = in_access ? cmd_q.addr  : '0;
  assign mem_wdata = in_access ? cmd_q.wdata : '0;

  assign cpu_gnt  = active  && (owner_q == OWN_CPU);
  assign dma_gnt  = active  && (owner_q == OWN_DMA);
  assign cpu_done = in_resp && (owner_q == OWN_CPU);
  assign dma_done = in_resp && (owner_q == OWN_DMA);
  assign busy     = active;
  assign rdata    = rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-timeline reference model.
module tb_mem_port_arbiter;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic        cpu_gnt, cpu_done, dma_gnt, dma_done, mem_valid, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] tbmem [64];

  assign mem_rdata = tbmem[mem_addr[7:2]];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done),
    .rdata(rdata), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second build with single-cycle latency.
  logic        c1_req = 0, c1_we = 0, d1_req = 0, d1_we = 0;
  logic [31:0] c1_addr = 0, c1_wdata = 0, d1_addr = 0, d1_wdata = 0;
  logic        c1_gnt, c1_done, d1_gnt, d1_done, mv1, mwe1, busy1;
  logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
  assign mrdata1 = maddr1 ^ 32'hCAFE0000;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_gnt(c1_gnt), .cpu_done(c1_done),
    .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
    .dma_gnt(d1_gnt), .dma_done(d1_done),
    .rdata(rdata1), .mem_valid(mv1), .mem_we(mwe1), .mem_addr(maddr1),
    .mem_wdata(mwdata1), .mem_rdata(mrdata1), .busy(busy1)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: position t within a transaction timeline
  // (0 = idle, 1..ML = command on the port, ML+1 = done cycle).
  int          t;
  bit          own, last;  // 0 = CPU, 1 = DMA
  logic        lwe;
  logic [31:0] laddr, lwdata, exp_rdata;
  logic [31:0] model_mem [64];

  task automatic model_reset();
    t = 0; own = 0; last = 1; exp_rdata = 0; lwe = 0; laddr = 0; lwdata = 0;
  endtask

  task automatic model_edge();
    if (t == 0) begin
      if (cpu_req || dma_req) begin
        own    = (cpu_req && dma_req) ? !last : dma_req;
        lwe    = own ? dma_we    : cpu_we;
        laddr  = own ? dma_addr  : cpu_addr;
        lwdata = own ? dma_wdata : cpu_wdata;
        t = 1;
      end
    end else if (t == ML + 1) begin
      t = 0;
    end else begin
      if (t == ML) begin
        if (lwe) model_mem[laddr[7:2]] = lwdata;
        else     exp_rdata = model_mem[laddr[7:2]];
        last = own;
      end
      t++;
    end
  endtask

  task automatic check_all();
    bit acc, act, rsp;
    acc = (t >= 1) && (t <= ML);
    act = (t != 0);
    rsp = (t == ML + 1);
    check("mem_valid", 32'(mem_valid), 32'(acc));
    check("mem_we",    32'(mem_we),    32'(acc && lwe));
    check("mem_addr",  mem_addr,       acc ? laddr  : 32'h0);
    check("mem_wdata", mem_wdata,      acc ? lwdata : 32'h0);
    check("cpu_gnt",   32'(cpu_gnt),   32'(act && !own));
    check("dma_gnt",   32'(dma_gnt),   32'(act && own));
    check("cpu_done",  32'(cpu_done),  32'(rsp && !own));
    check("dma_done",  32'(dma_done),  32'(rsp && own));
    check("busy",      32'(busy),      32'(act));
    check("rdata",     rdata,          exp_rdata);
    check("gnt_excl",  32'(cpu_gnt & dma_gnt), 32'h0);
  endtask

  // Requesters: hold until done, stay low the cycle after, optionally reissue.
  bit          cpu_auto = 0, dma_auto = 0, cpu_cool = 0, dma_cool = 0;
  int unsigned cpu_pct = 0, dma_pct = 0;
  int          order[$];

  task automatic req_update();
    if (t == ML + 1 && !own) begin cpu_req = 0; cpu_cool = 1; end
    else if (cpu_cool) cpu_cool = 0;
    else if (cpu_auto && !cpu_req && $urandom_range(99) < cpu_pct) begin
      cpu_req = 1; cpu_we = 1'($urandom_range(1));
      cpu_addr = 32'($urandom_range(63)) << 2; cpu_wdata = $urandom;
    end
    if (t == ML + 1 && own) begin dma_req = 0; dma_cool = 1; end
    else if (dma_cool) dma_cool = 0;
    else if (dma_auto && !dma_req && $urandom_range(99) < dma_pct) begin
      dma_req = 1; dma_we = 1'($urandom_range(1));
      dma_addr = 32'($urandom_range(63)) << 2; dma_wdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (cpu_done) order.push_back(0);
    if (dma_done) order.push_back(1);
    req_update();
    if (mem_valid && mem_we) tbmem[mem_addr[7:2]] = mem_wdata;
  endtask

  task automatic run_quiet(input string tag);
    int n = 0;
    while (!(t == 0 && !cpu_req && !dma_req && !cpu_cool && !dma_cool) && n < 60) begin
      step(); n++;
    end
    check(tag, 32'(n < 60), 32'h1);
  endtask

  task automatic issue_cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic issue_dma(input logic we, input logic [31:0] a, input logic [31:0] d);
    dma_req = 1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 0; cpu_req = 0; dma_req = 0; cpu_cool = 0; dma_cool = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1;
  endtask

  logic ev_v [6] = '{1, 0, 0, 1, 0, 0};
  logic ev_cd[6] = '{0, 1, 0, 0, 0, 0};
  logic ev_dd[6] = '{0, 0, 0, 0, 1, 0};
  logic ev_b [6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      tbmem[i] = v; model_mem[i] = v;
    end
    tbmem[4] = 32'hDEADBEEF; model_mem[4] = 32'hDEADBEEF;

    // Reset state
    model_reset();
    #2 check_all();
    @(negedge clk) reset = 1;

    // Single CPU read of 0x10
    issue_cpu(0, 32'h10, 0);
    run_quiet("t1_timeout");
    check("t1_rdata", rdata, 32'hDEADBEEF);

    // DMA write then CPU read of the same word
    issue_dma(1, 32'h20, 32'h12345678);
    run_quiet("t2w_timeout");
    check("t2_rdata_after_write", rdata, 32'hDEADBEEF);
    issue_cpu(0, 32'h20, 0);
    run_quiet("t2r_timeout");
    check("t2_rdata", rdata, 32'h12345678);

    // Both requesting continuously from reset: strict alternation
    hard_reset();
    order.delete();
    cpu_auto = 1; dma_auto = 1; cpu_pct = 100; dma_pct = 100;
    for (int n = 0; n < 60 && order.size() < 4; n++) step();
    cpu_auto = 0; dma_auto = 0;
    run_quiet("t3_timeout");
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_order%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFF, 32'(i % 2));

    // Address change during ACCESS is ignored
    issue_cpu(0, 32'h10, 0);
    step();
    cpu_addr = 32'h40;
    run_quiet("t4_timeout");
    check("t4_rdata", rdata, model_mem[4]);

    // Async reset in the middle of ACCESS
    issue_cpu(0, 32'h30, 0);
    step();
    #3 reset = 0;
    #1;
    model_reset(); cpu_req = 0; cpu_cool = 0;
    check_all();
    #2 reset = 1;
    for (int i = 0; i < 4; i++) step();
    issue_cpu(0, 32'h10, 0);
    run_quiet("t5_timeout");
    check("t5_rdata", rdata, model_mem[4]);

    // Random traffic
    cpu_auto = 1; dma_auto = 1; cpu_pct = 35; dma_pct = 50;
    for (int i = 0; i < 300; i++) step();
    cpu_auto = 0; dma_auto = 0;
    run_quiet("t6_timeout");

    // MEM_LATENCY=1 build: CPU read then DMA write, period 3
    @(posedge clk); #1;
    c1_req = 1; c1_we = 0; c1_addr = 32'h8;
    d1_req = 1; d1_we = 1; d1_addr = 32'hC; d1_wdata = 32'h55;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("ml1_valid%0d", k), 32'(mv1),     32'(ev_v[k-1]));
      check($sformatf("ml1_cdone%0d", k), 32'(c1_done), 32'(ev_cd[k-1]));
      check($sformatf("ml1_ddone%0d", k), 32'(d1_done), 32'(ev_dd[k-1]));
      check($sformatf("ml1_busy%0d", k),  32'(busy1),   32'(ev_b[k-1]));
      if (k == 1) check("ml1_cgnt", 32'(c1_gnt), 32'h1);
      if (k == 2) begin
        check("ml1_rdata", rdata1, 32'hCAFE0008);
        c1_req = 0;
      end
      if (k == 4) begin
        check("ml1_dgnt", 32'(d1_gnt), 32'h1);
        check("ml1_we", 32'(mwe1), 32'h1);
        check("ml1_addr", maddr1, 32'hC);
        check("ml1_wdata", mwdata1, 32'h55);
      end
      if (k == 5) d1_req = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
